// File: rtl/triangle_assembly.sv
// Groups three consecutive vertices into a triangle (provoking-vertex attributes)
// and buffers completed triangles in a small FIFO with a valid/ready output.
module triangle_assembly #(
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        clear_in,
  input  logic                        valid_in,
  input  logic [2:0][31:0]            position_in,
  input  logic [11:0]                 normal_in,
  input  logic [11:0]                 material_in,
  input  logic                        ready_in,
  output logic                        valid_out,
  output logic [2:0][2:0][31:0]       triangle_out,
  output logic [11:0]                 normal_out,
  output logic [11:0]                 material_out,
  output logic                        overflow_out,
  output logic [COUNT_WIDTH-1:0]      triangle_count_out
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S0, S1, S2} slot_t;

  logic                  reset_meta;
  logic                  reset_n;
  slot_t                 slot;
  logic [2:0][31:0]      v0;
  logic [2:0][31:0]      v1;
  logic [11:0]           normal0;
  logic [11:0]           material0;
  logic [2:0][2:0][31:0] pos_mem [DEPTH];
  logic [11:0]           normal_mem [DEPTH];
  logic [11:0]           material_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           occupancy;
  logic                  pop;
  logic                  complete;
  logic                  push;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      reset_meta <= 1'b0;
      reset_n    <= 1'b0;
    end else begin
      reset_meta <= 1'b1;
      reset_n    <= reset_meta;
    end
  end

  assign valid_out = (occupancy != '0);
  assign pop       = !clear_in && valid_out && ready_in;
  assign complete  = !clear_in && valid_in && (slot == S2);
  assign push      = complete && ((occupancy < FULL) || pop);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      slot      <= S0;
      v0        <= '0;
      v1        <= '0;
      normal0   <= '0;
      material0 <= '0;
    end else if (clear_in) begin
      slot <= S0;
    end else if (valid_in) begin
      case (slot)
        S0: begin
          v0        <= position_in;
          normal0   <= normal_in;
          material0 <= material_in;
          slot      <= S1;
        end
        S1: begin
          v1   <= position_in;
          slot <= S2;
        end
        default: slot <= S0;
      endcase
    end
  end

  // Triangle FIFO: the head entry drives the outputs directly from registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pos_mem[i]      <= '0;
        normal_mem[i]   <= '0;
        material_mem[i] <= '0;
      end
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occupancy          <= '0;
      overflow_out       <= 1'b0;
      triangle_count_out <= '0;
    end else if (clear_in) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occupancy          <= '0;
      overflow_out       <= 1'b0;
      triangle_count_out <= '0;
    end else begin
      if (push) begin
        pos_mem[wr_ptr]      <= {position_in, v1, v0};
        normal_mem[wr_ptr]   <= normal0;
        material_mem[wr_ptr] <= material0;
        wr_ptr               <= wr_ptr + 1'b1;
        triangle_count_out   <= triangle_count_out + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (complete && !push) begin
        overflow_out <= 1'b1;
      end
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign triangle_out = pos_mem[rd_ptr];
  assign normal_out   = normal_mem[rd_ptr];
  assign material_out = material_mem[rd_ptr];

endmodule

// File: tb/tb_triangle_assembly.sv
// Scoreboard bench: stimulus queues expected triangles, a monitor checks each
// handshake and data stability while the output is stalled.
module tb_triangle_assembly;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic                   clear_in = 1'b0;
  logic                   valid_in = 1'b0;
  logic [2:0][31:0]       position_in = '0;
  logic [11:0]            normal_in = '0;
  logic [11:0]            material_in = '0;
  logic                   ready_in = 1'b0;
  logic                   valid_out;
  logic [2:0][2:0][31:0]  triangle_out;
  logic [11:0]            normal_out;
  logic [11:0]            material_out;
  logic                   overflow_out;
  logic [15:0]            triangle_count_out;

  typedef struct packed {
    logic [2:0][2:0][31:0] pos;
    logic [11:0]           nrm;
    logic [11:0]           mat;
  } tri_t;

  tri_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  bit   held   = 0;
  tri_t saved;

  triangle_assembly #(.DEPTH(4), .COUNT_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .valid_in(valid_in),
    .position_in(position_in), .normal_in(normal_in), .material_in(material_in),
    .ready_in(ready_in), .valid_out(valid_out), .triangle_out(triangle_out),
    .normal_out(normal_out), .material_out(material_out),
    .overflow_out(overflow_out), .triangle_count_out(triangle_count_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic tri_t mk(input int a);
    tri_t t;
    for (int v = 0; v < 3; v++) begin
      t.pos[v][0] = 32'(a + v);
      t.pos[v][1] = 32'(2 * (a + v));
      t.pos[v][2] = 32'(3 * (a + v));
    end
    t.nrm = 12'(10 + a);
    t.mat = 12'(20 + a);
    return t;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int n, input bit clr = 1'b0);
    valid_in       = 1'b1;
    clear_in       = clr;
    position_in[0] = 32'(n);
    position_in[1] = 32'(2 * n);
    position_in[2] = 32'(3 * n);
    normal_in      = 12'(10 + n);
    material_in    = 12'(20 + n);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    @(posedge clk_in);
    #1;
    clear_in = 1'b0;
  endtask

  // Monitor: a transfer happens on the next rising edge when valid && ready here.
  always @(negedge clk_in) begin
    tri_t cur;
    tri_t e;
    cur = '{pos: triangle_out, nrm: normal_out, mat: material_out};
    if (held && valid_out) check("stall_stable", 320'(cur), 320'(saved));
    held = 1'b0;
    if (valid_out && ready_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_triangle: got %0h required no output", cur);
      end else begin
        e = sb.pop_front();
        check("triangle", 320'(cur.pos), 320'(e.pos));
        check("normal", 320'(cur.nrm), 320'(e.nrm));
        check("material", 320'(cur.mat), 320'(e.mat));
        pops++;
      end
    end else if (valid_out) begin
      held  = 1'b1;
      saved = cur;
    end
  end

  initial begin
    int base;
    #1 rst_in = 1'b0;
    #1;
    check("rst_valid", 320'(valid_out), 320'(0));
    check("rst_triangle", 320'(triangle_out), 320'(0));
    check("rst_count", 320'(triangle_count_out), 320'(0));
    check("rst_overflow", 320'(overflow_out), 320'(0));
    #20 rst_in = 1'b1;
    idle(3);

    // Back-to-back vertices, downstream always ready.
    ready_in = 1'b1;
    sb.push_back(mk(1));
    sb.push_back(mk(4));
    for (int n = 1; n <= 6; n++) begin
      send(n);
      if (n == 3) check("latency_b2b", 320'(valid_out), 320'(1));
    end
    idle(3);
    check("count_b2b", 320'(triangle_count_out), 320'(2));
    check("drained_b2b", 320'(sb.size()), 320'(0));
    check("idle_valid_b2b", 320'(valid_out), 320'(0));

    // Stalled downstream: four buffered, fifth dropped.
    do_clear();
    ready_in = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back(mk(10 + 3 * k));
    for (int n = 10; n <= 24; n++) send(n);
    check("overflow_set", 320'(overflow_out), 320'(1));
    check("count_full", 320'(triangle_count_out), 320'(4));
    check("valid_held", 320'(valid_out), 320'(1));
    ready_in = 1'b1;
    idle(6);
    check("drained_full", 320'(sb.size()), 320'(0));
    check("valid_after_drain", 320'(valid_out), 320'(0));
    check("overflow_sticky", 320'(overflow_out), 320'(1));

    // Full FIFO with a pop in the same cycle as the completing vertex.
    do_clear();
    check("overflow_cleared", 320'(overflow_out), 320'(0));
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back(mk(30 + 3 * k));
    for (int n = 30; n <= 43; n++) send(n);
    ready_in = 1'b1;
    send(44);
    ready_in = 1'b0;
    check("overflow_push_pop", 320'(overflow_out), 320'(0));
    check("count_push_pop", 320'(triangle_count_out), 320'(5));
    base = pops;
    ready_in = 1'b1;
    idle(8);
    check("occupancy_push_pop", 320'(pops - base), 320'(4));
    check("drained_push_pop", 320'(sb.size()), 320'(0));

    // Clear arriving with the third vertex drops the partial triangle.
    do_clear();
    send(50);
    send(51);
    send(52, 1'b1);
    check("valid_after_clear", 320'(valid_out), 320'(0));
    check("count_after_clear", 320'(triangle_count_out), 320'(0));
    sb.push_back(mk(7));
    for (int n = 7; n <= 9; n++) send(n);
    idle(3);
    check("count_clear_case", 320'(triangle_count_out), 320'(1));
    check("drained_clear_case", 320'(sb.size()), 320'(0));

    // Vertices with idle gaps.
    do_clear();
    sb.push_back(mk(1));
    sb.push_back(mk(4));
    for (int n = 1; n <= 6; n++) begin
      send(n);
      if (n == 3) check("latency_gaps", 320'(valid_out), 320'(1));
      idle(2);
    end
    idle(2);
    check("count_gaps", 320'(triangle_count_out), 320'(2));
    check("drained_gaps", 320'(sb.size()), 320'(0));

    // Asynchronous reset mid-triangle with a buffered triangle.
    do_clear();
    ready_in = 1'b0;
    sb.push_back(mk(60));
    for (int n = 60; n <= 64; n++) send(n);
    check("valid_before_reset", 320'(valid_out), 320'(1));
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    #1;
    check("async_valid", 320'(valid_out), 320'(0));
    check("async_triangle", 320'(triangle_out), 320'(0));
    check("async_normal", 320'(normal_out), 320'(0));
    check("async_material", 320'(material_out), 320'(0));
    check("async_count", 320'(triangle_count_out), 320'(0));
    sb.delete();
    #3 rst_in = 1'b1;
    idle(3);
    ready_in = 1'b1;
    sb.push_back(mk(70));
    for (int n = 70; n <= 72; n++) send(n);
    idle(3);
    check("count_after_reset", 320'(triangle_count_out), 320'(1));
    check("drained_after_reset", 320'(sb.size()), 320'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triangle_assembly.md
Name: triangle_assembly

Overview:
- Directly downstream of vertex_fetch. Groups every three consecutive valid vertices into one triangle.
- Each triangle carries three positions plus the normal and material IDs of its first (provoking) vertex.
- vertex_fetch has no stall input, so the block takes one vertex per cycle unconditionally. Completed triangles are buffered in a small FIFO and sent to the rasterizer with a valid/ready handshake.

Parameters:
- DEPTH, 4, triangle FIFO entries; power of two, at least 2.
- COUNT_WIDTH, 16, width of triangle_count_out.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous flush at start of frame; drops any partial triangle and clears the FIFO, overflow flag and counter.
- valid_in  input  1  vertex valid (from vertex_fetch valid_out).
- position_in  input  3x32  vertex x,y,z as IEEE-754 single; passed through unmodified.
- normal_in  input  12  normal ID of the vertex.
- material_in  input  12  material ID of the vertex.
- ready_in  input  1  downstream can accept a triangle.
- valid_out  output  1  FIFO head holds a triangle.
- triangle_out  output  3x3x32  [v][axis] positions; v0 is the first-arrived vertex.
- normal_out  output  12  normal ID of v0.
- material_out  output  12  material ID of v0.
- overflow_out  output  1  sticky; a completed triangle was dropped because the FIFO was full.
- triangle_count_out  output  COUNT_WIDTH  triangles accepted into the FIFO; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (rst_in low, asynchronous): slot counter = 0, FIFO empty, valid_out = 0, overflow_out = 0, triangle_count_out = 0, triangle_out/normal_out/material_out = 0. Release is synchronised to clk_in.
- Slot counter: 2-bit, states S0 → S1 → S2 → S0; advances only on valid_in.
  - S0 + valid_in: latch position into v0; latch normal_in and material_in.
  - S1 + valid_in: latch position into v1.
  - S2 + valid_in: the triangle is {v0, v1, position_in}; attempt a push this cycle, then return to S0.
  - Normal and material of v1 and v2 are ignored.
- Push rule: the push succeeds if occupancy < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the triangle is discarded, overflow_out is set, and triangle_count_out is unchanged.
  - The slot counter returns to S0 whether or not the push succeeds.
- Latency: valid_out is high the cycle after the third vertex's valid_in (FIFO previously empty). Minimum vertex-in to triangle-out is 1 cycle.
- FIFO: DEPTH-entry register array with read/write pointers of log2(DEPTH) bits, wrapping, plus an occupancy counter of log2(DEPTH)+1 bits.
  - valid_out = (occupancy != 0).
  - Outputs show the head entry straight from registers (no combinational path from inputs).
  - Pop occurs when valid_out && ready_in; the head then advances the next cycle.
  - Output data is stable while valid_out && !ready_in.
  - Push and pop in the same cycle leaves occupancy unchanged. With an empty FIFO this is not a bypass: the new triangle appears the next cycle.
- triangle_count_out increments by 1 on each successful push.
- clear_in high, evaluated before valid_in:
  - slot counter = 0, FIFO emptied (pointers and occupancy = 0), overflow_out = 0, triangle_count_out = 0.
  - A vertex presented in the same cycle is dropped; no pop is performed.
  - valid_out is 0 the following cycle.
- ready_in while valid_out = 0 has no effect.
- valid_in is ignored when low. Positions are never inspected (no culling or NaN handling).

Test Plan:
- Reset, ready_in = 1; send 6 vertices back-to-back with positions 1..6 (x = n, y = 2n, z = 3n), normal = 10+n, material = 20+n. Expect 2 triangles: the first has x = {1,2,3}, normal 11, material 21, valid_out high 1 cycle after vertex 3; the second has x = {4,5,6}, normal 14, material 24. triangle_count_out = 2.
- ready_in = 0; send 15 vertices (5 triangles) with DEPTH = 4. Expect valid_out held with data stable, triangles 1–4 buffered, the 5th dropped, overflow_out = 1, count = 4. Then raise ready_in: expect triangles 1–4 in order, then valid_out = 0.
- FIFO full, ready_in = 1, and a 3rd vertex arriving in the same cycle as a pop. Expect the push accepted, occupancy stays 4, overflow_out stays 0.
- Send 2 vertices, assert clear_in together with a 3rd vertex, then send 3 vertices 7, 8, 9. Expect exactly one triangle with x = {7,8,9}, count = 1.
- Send valid_in with gaps (1 vertex every 3 cycles). Expect triangles identical to the back-to-back case; the slot counter does not advance on idle cycles.
- Pull rst_in low asynchronously mid-triangle with the FIFO non-empty. Expect valid_out = 0 and all outputs 0 immediately, without a clock edge; the next 3 vertices form a triangle starting at v0.
